// File: rtl/fp_pkg.sv
// fp_pkg: field widths, exponent bias, FSM states and the signed exponent
// type shared by the 16-bit (sign/exp8/frac7) divider.
package fp_pkg;
  localparam int BIAS   = 127;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;
  localparam int WORD_W = SIGN_W + EXP_W + FRAC_W;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int REM_W  = SIG_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
  typedef logic signed [9:0] exp_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, producing one quotient bit and the
// shifted partial remainder for the next cycle.
module div_step
  import fp_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  logic [SIG_W-1:0] div,
  output logic             q_bit,
  output logic [REM_W-1:0] next_rem
);
  logic [REM_W-1:0] w_div_ext;
  logic [REM_W-1:0] w_diff;
  logic [REM_W-1:0] w_sel;

  // rem < 2*div holds every step, so the shifted result always fits REM_W bits
  assign w_div_ext = {1'b0, div};
  assign q_bit     = (rem >= w_div_ext);
  assign w_diff    = rem - w_div_ext;
  assign w_sel     = q_bit ? w_diff : rem;
  assign next_rem  = w_sel << 1;
endmodule

// File: rtl/divide.sv
// divide: iterative restoring divider for 16-bit sign/exp8/frac7 operands.
// Define DIVIDE_SPECIAL_EN for zero-operand and exponent range handling.
module divide
  import fp_pkg::*;
#(
  parameter int QBITS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] a_reg,
  input  logic [WORD_W-1:0] b_reg,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] out_divide,
  output logic              div_by_zero
);
  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one quotient bit per cycle, QBITS cycles
  // NORM  | normalise quotient, pack result
  // DONE  | publish result, pulse done
  localparam int               CNT_W    = $clog2(QBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [REM_W-1:0]  r_rem;
  logic [SIG_W-1:0]  r_div;
  logic [QBITS-1:0]  r_quot;
  logic              r_sign;
  exp_t              r_exp;
  logic [WORD_W-1:0] r_res;
  logic [WORD_W-1:0] r_out;
  logic              r_busy;
  logic              r_done;

  exp_t              w_exp_in;
  exp_t              w_exp_n;
  logic [FRAC_W-1:0] w_frac;
  logic [WORD_W-1:0] w_result;
  logic              w_qbit;
  logic [REM_W-1:0]  w_next_rem;

  div_step u_div_step (
    .rem      (r_rem),
    .div      (r_div),
    .q_bit    (w_qbit),
    .next_rem (w_next_rem)
  );

  assign w_exp_in = exp_t'({2'b00, a_reg[14:7]}) - exp_t'({2'b00, b_reg[14:7]})
                  + exp_t'(BIAS);
  assign w_exp_n  = r_quot[QBITS-1] ? r_exp : r_exp - exp_t'(1);
  assign w_frac   = r_quot[QBITS-1] ? r_quot[QBITS-2 -: FRAC_W]
                                    : r_quot[QBITS-3 -: FRAC_W];

`ifdef DIVIDE_SPECIAL_EN
  logic r_a_zero;
  logic r_b_zero;
  logic r_res_dbz;
  logic r_dbz;
  logic w_dbz;

  always_comb begin
    w_result = {r_sign, w_exp_n[EXP_W-1:0], w_frac};
    w_dbz    = 1'b0;
    if (r_b_zero) begin
      w_result = {r_sign, 8'hFF, 7'h00};
      w_dbz    = 1'b1;
    end else if (r_a_zero) begin
      w_result = {r_sign, 15'h0000};
    end else if (w_exp_n >= 10'sd255) begin
      w_result = {r_sign, 8'hFF, 7'h00};
    end else if (w_exp_n <= 10'sd0) begin
      w_result = {r_sign, 15'h0000};
    end
  end

  assign div_by_zero = r_dbz;
`else
  logic w_unused_exp_hi;

  // exponent wraps modulo 256 when special handling is compiled out
  assign w_result        = {r_sign, w_exp_n[EXP_W-1:0], w_frac};
  assign w_unused_exp_hi = ^w_exp_n[9:8];
  assign div_by_zero     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quot  <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_res   <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DIVIDE_SPECIAL_EN
      r_a_zero  <= 1'b0;
      r_b_zero  <= 1'b0;
      r_res_dbz <= 1'b0;
      r_dbz     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !r_done) begin
            r_sign  <= a_reg[15] ^ b_reg[15];
            r_exp   <= w_exp_in;
            r_rem   <= {2'b01, a_reg[6:0]};
            r_div   <= {1'b1, b_reg[6:0]};
            r_quot  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
`ifdef DIVIDE_SPECIAL_EN
            r_a_zero <= (a_reg[14:7] == 8'h00);
            r_b_zero <= (b_reg[14:7] == 8'h00);
`endif
          end
        end
        CALC: begin
          r_rem  <= w_next_rem;
          r_quot <= {r_quot[QBITS-2:0], w_qbit};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= NORM;
        end
        NORM: begin
          r_res   <= w_result;
          r_busy  <= 1'b0;
          r_state <= DONE;
`ifdef DIVIDE_SPECIAL_EN
          r_res_dbz <= w_dbz;
`endif
        end
        DONE: begin
          r_done  <= 1'b1;
          r_out   <= r_res;
          r_state <= IDLE;
`ifdef DIVIDE_SPECIAL_EN
          r_dbz <= r_res_dbz;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign out_divide = r_out;
endmodule

// File: tb/tb_divide.sv
// tb_divide: scoreboard bench for the iterative divider; a reference model
// computes quotients with plain integer arithmetic.
module tb_divide;
  localparam int QBITS = 9;

  typedef struct {
    logic [15:0] out;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic        busy;
  logic        done;
  logic [15:0] out_divide;
  logic        div_by_zero;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   busy_from = 1;
  int   busy_to   = 0;
  int   pending_done = -1;
  exp_t sb[$];

  divide #(.QBITS(QBITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_reg       (a_reg),
    .b_reg       (b_reg),
    .busy        (busy),
    .done        (done),
    .out_divide  (out_divide),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // quotient as a scaled integer, then normalised so the leading one is implied
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int   sa   = 128 + int'(a[6:0]);
    int   sb_v = 128 + int'(b[6:0]);
    int   ea   = int'(a[14:7]);
    int   eb   = int'(b[14:7]);
    int   q    = (sa << (QBITS - 1)) / sb_v;
    int   e    = ea - eb + 127;
    int   frac;
    logic s    = a[15] ^ b[15];
    if (q >= (1 << (QBITS - 1))) begin
      frac = (q >> (QBITS - 8)) & 127;
    end else begin
      frac = (q >> (QBITS - 9)) & 127;
      e    = e - 1;
    end
    r.out      = {s, 8'(e & 255), 7'(frac)};
    r.dbz      = 1'b0;
    r.done_cyc = 0;
`ifdef DIVIDE_SPECIAL_EN
    if (eb == 0) begin
      r.out = {s, 15'h7F80};
      r.dbz = 1'b1;
    end else if (ea == 0) begin
      r.out = {s, 15'h0000};
    end else if (e >= 255) begin
      r.out = {s, 15'h7F80};
    end else if (e <= 0) begin
      r.out = {s, 15'h0000};
    end
`endif
    return r;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] req_out, input logic req_dbz);
    exp_t e;
    @(negedge clk);
    a_reg = a;
    b_reg = b;
    start = 1'b1;
    if (cyc > pending_done && !rst) begin
      e.out        = req_out;
      e.dbz        = req_dbz;
      e.done_cyc   = cyc + QBITS + 3;
      pending_done = e.done_cyc;
      busy_from    = cyc + 1;
      busy_to      = cyc + QBITS + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [15:0] a, input logic [15:0] b);
    exp_t m = model(a, b);
    issue(a, b, m.out, m.dbz);
  endtask

  task automatic wait_idle();
    int budget = 4 * QBITS + 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_done_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_divide", int'(out_divide), int'(e.out));
        chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
        chk("done_latency", cyc, e.done_cyc);
      end
    end
    chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    rst   = 1'b1;
    start = 1'b0;
    a_reg = '0;
    b_reg = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_out", int'(out_divide), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    #1 rst = 1'b0;

    issue(16'h3F80, 16'h3F80, 16'h3F80, 1'b0);
    wait_idle();
    issue(16'h40C0, 16'h4000, 16'h4040, 1'b0);
    wait_idle();
    issue(16'h3F80, 16'h4040, 16'h3EAA, 1'b0);
    wait_idle();

    // a second start while busy must not produce a second done
    issue(16'hC000, 16'h3F00, 16'hC080, 1'b0);
    repeat (2) @(negedge clk);
    issue(16'h4000, 16'h3F80, 16'h0000, 1'b0);
    wait_idle();

`ifdef DIVIDE_SPECIAL_EN
    issue(16'h3F80, 16'h0000, 16'h7F80, 1'b1);
`else
    issue(16'h3F80, 16'h0000, 16'h7F00, 1'b0);
`endif
    wait_idle();

    // reset mid-calculation abandons the operation
    issue(16'h40C0, 16'h4000, 16'h4040, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    busy_to      = -1;
    pending_done = -1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_out", int'(out_divide), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (QBITS + 4) @(negedge clk);
    chk("abort_no_done_out", int'(out_divide), 0);

    issue(16'h40C0, 16'h4000, 16'h4040, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) b[14:7] = 8'h00;
      if ($urandom_range(0, 7) == 0) a[14:7] = 8'h00;
      issue_model(a, b);
      wait_idle();
    end

    repeat (QBITS + 4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
